// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_core
//  Purpose  : Handshaked ALU core. Accepts one operation (A, B, SelOp) per
//             in_valid/in_ready transfer and returns a registered result C
//             with flags {ERR, V, Cy, N, Z} on out_valid/out_ready. Every op
//             except MUL completes in one cycle. MUL uses an iterative
//             shift-add engine that handles one multiplier bit per cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand/result width (>= 4, power of two)
//    SHW        shift-amount width, taken from B[SHW-1:0]
//  Ports
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    in_valid   request valid            in_ready  core can accept
//    A, B       operands                 SelOp     4-bit opcode
//    out_valid  result valid             out_ready consumer takes result
//    C          result                   flags     {ERR, V, Cy, N, Z}
//  Configuration macro
//    ALU_MUL_EN defined   : MUL (0011) runs on the iterative engine
//    ALU_MUL_EN undefined : no multiplier logic; 0011 is an illegal opcode
// ============================================================================
module alu_seq_core #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       SelOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [4:0]       flags
);

  localparam logic [3:0] OP_NOT = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t state;

  // A new op may enter while idle, or while the finished result is being
  // retired on this same edge (back-to-back issue).
  logic accept;
  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs; its result is only
  // registered on the accept edge, which is what captures the operands.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_c;
  logic             alu_cy;
  logic             alu_v;
  logic             alu_err;

  assign add_w = {1'b0, A} + {1'b0, B};
  // The extra top bit of the widened difference is the unsigned borrow.
  assign sub_w = {1'b0, A} - {1'b0, B};

  always_comb begin
    alu_c   = '0;
    alu_cy  = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (SelOp)
      OP_NOT: alu_c = ~A;
      OP_ADD: begin
        alu_c  = add_w[WIDTH-1:0];
        alu_cy = add_w[WIDTH];
        // Same-sign operands producing a differently signed sum overflow.
        alu_v  = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c  = sub_w[WIDTH-1:0];
        alu_cy = sub_w[WIDTH];
        // Opposite-sign operands where the difference takes B's sign overflow.
        alu_v  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
`ifdef ALU_MUL_EN
      OP_MUL: alu_c = '0;   // result comes from the multiplier engine
`else
      OP_MUL: alu_err = 1'b1;
`endif
      OP_AND: alu_c = A & B;
      OP_OR:  alu_c = A | B;
      OP_XOR: alu_c = A ^ B;
      OP_SHR: alu_c = A >> B[SHW-1:0];
      OP_SHL: alu_c = A << B[SHW-1:0];
      default: alu_err = 1'b1;
    endcase
  end

  // Flag vector packing: {ERR, V, Cy, N, Z}.
  function automatic logic [4:0] pack_flags(input logic [WIDTH-1:0] c,
                                             input logic err,
                                             input logic v,
                                             input logic cy);
    pack_flags = {err, v, cy, c[WIDTH-1], ~|c};
  endfunction

  // --------------------------------------------------------------------------
  // Iterative multiplier engine
  // --------------------------------------------------------------------------
  logic is_mul;

`ifdef ALU_MUL_EN
  localparam int CNTW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [CNTW-1:0]    mul_cnt;

  assign is_mul = (SelOp == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Control FSM with registered result, flags and out_valid
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      C          <= '0;
      flags      <= '0;
      out_valid  <= 1'b0;
`ifdef ALU_MUL_EN
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept && is_mul) begin
`ifdef ALU_MUL_EN
            mul_acc    <= '0;
            mul_mcand  <= {{WIDTH{1'b0}}, A};
            mul_mplier <= B;
            mul_cnt    <= '0;
`endif
            out_valid  <= 1'b0;
            state      <= MUL_BUSY;
          end else if (accept) begin
            C         <= alu_c;
            flags     <= pack_flags(alu_c, alu_err, alu_v, alu_cy);
            out_valid <= 1'b1;
            state     <= DONE;
          end else if ((state == DONE) && out_ready) begin
            // Result retired with nothing new behind it; C/flags are kept
            // but no longer flagged valid.
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
`ifdef ALU_MUL_EN
        MUL_BUSY: begin
          if (mul_cnt != CNTW'(WIDTH)) begin
            // One multiplier bit per cycle: add the shifted multiplicand
            // when the current LSB is set.
            if (mul_mplier[0]) begin
              mul_acc <= mul_acc + mul_mcand;
            end
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 1'b1;
          end else begin
            // All WIDTH bits consumed; publish on the following edge so the
            // result lands WIDTH+1 edges after the accept.
            C         <= mul_acc[WIDTH-1:0];
            flags     <= pack_flags(mul_acc[WIDTH-1:0], 1'b0, 1'b0,
                                    |mul_acc[2*WIDTH-1:WIDTH]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor to the team's 32-bit combinational ALU. Accepts one operation (A, B, SelOp) per valid/ready transfer and returns a registered result C with status flags. Most ops complete in 1 cycle; MUL runs on an iterative shift-add engine. Sits between the operand/issue stage and the writeback stage of the datapath.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width taken from B[SHW-1:0].
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: operation request.
- `in_ready`  output  1: core can accept a request this cycle.
- `A`, `B`  input  WIDTH: operands; sampled only on accept.
- `SelOp`  input  4: opcode; sampled only on accept.
- `out_valid`  output  1: C and flags hold a result.
- `out_ready`  input  1: consumer takes the result.
- `C`  output  WIDTH: result.
- `flags`  output  5: {ERR, V, Cy, N, Z}.

## Operation
- Opcodes:
  - 0000 NOT A
  - 0001 A+B
  - 0010 A−B
  - 0011 MUL (low WIDTH bits of unsigned A·B)
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 0111 logical A>>B[SHW-1:0]
  - 1000 A<<B[SHW-1:0]
  - 1001–1111 illegal: C=0, ERR=1.
- Flags:
  - Z = (C==0).
  - N = C[WIDTH-1].
  - ADD: Cy = carry out; V = signed overflow.
  - SUB: Cy = borrow (A<B unsigned); V = signed overflow.
  - MUL: Cy = 1 if upper WIDTH bits of the 2·WIDTH product are nonzero; V=0.
  - All other ops: Cy=V=0.
  - ERR=1 only for illegal opcodes.
- FSM states:
  - IDLE → DONE on accepting a single-cycle op.
  - IDLE → MUL_BUSY on accepting MUL.
  - MUL_BUSY → DONE after WIDTH iterations (one multiplier bit per cycle, 2·WIDTH accumulator).
  - DONE → IDLE on out_ready with no new accept.
  - DONE → DONE / MUL_BUSY on out_ready together with a new accept (back-to-back).
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is forced 0 while rst=1.
- Operands, opcode and multiplier state are captured internally on accept. Input changes afterwards have no effect.
- Reset values: state=IDLE, C=0, flags=0, out_valid=0, multiplier accumulator/counter=0.

## Timing
- Accept = rising edge with in_valid && in_ready.
- Single-cycle op: C, flags and out_valid are valid immediately after the accept edge (latency 1).
- MUL: out_valid rises WIDTH+1 edges after the accept edge.
- Result is held stable (C, flags, out_valid) until the edge where out_ready=1.
- Back-to-back: in DONE with out_ready=1 and in_valid=1, the result is retired and the new op is accepted on the same edge. For a single-cycle op the new result appears on the next cycle, giving throughput 1/cycle.
- in_valid while busy (MUL_BUSY, or DONE without out_ready) is not accepted. The requester must hold its request.
- rst asserted at any edge, including mid-MUL or in DONE, aborts the op: the result is discarded, reset values are applied, and in_ready=1 on the cycle after rst deasserts.
- Shift by 0 returns A. The shift amount uses only B[SHW-1:0], so amounts ≥ WIDTH are impossible.

## Configuration
- `ALU_MUL_EN` defined: MUL engine present; 0011 behaves as above.
- `ALU_MUL_EN` undefined: no multiplier logic and MUL_BUSY is unreachable. 0011 is treated as illegal: single-cycle, C=0, ERR=1.

## Test plan
All cases use WIDTH=32.
- A=15, B=13: ADD → C=28, flags=0. SUB → C=2. SUB with A=13, B=15 → C=0xFFFFFFFE, N=1, Cy=1. Each result appears 1 cycle after accept.
- ADD A=0x7FFFFFFF, B=1 → C=0x80000000, V=1, N=1, Cy=0. ADD A=0xFFFFFFFF, B=1 → C=0, Z=1, Cy=1.
- MUL 15×13 → C=195, out_valid exactly 33 edges after accept. MUL 0x10000×0x10000 → C=0, Z=1, Cy=1. Without ALU_MUL_EN: MUL 15×13 → C=0, ERR=1 after 1 cycle.
- A=15, B=2: SHR → 3; SHL → 60. NOT 15 → 0xFFFFFFF0, N=1. SelOp=1111 → C=0, ERR=1, Z=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result. C/flags stay stable, in_ready=0, and a pending in_valid is not accepted. Then issue back-to-back ADDs with out_ready=1: one result per cycle.
- Assert rst for 1 cycle, 10 cycles into a MUL. out_valid never rises for that MUL, outputs take reset values, in_ready=1 next cycle, and a following AND 15&13 → 13.
